// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline defines: NOP instruction codes, NOP payload fill and
// state encodings for the pipeline skid stage.
package pipe_skid_reg_pkg;

  localparam logic [3:0] NOP_OP           = 4'h0;
  localparam logic [1:0] NOP_SEL          = 2'h0;
  localparam logic       NOP_PAYLOAD_FILL = 1'b0;

  // Encodings double as the held-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

  function automatic logic is_nop_op(input logic [3:0] op, input logic [1:0] sel);
    return (op == NOP_OP) && (sel == NOP_SEL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
// rst and clr both force zero on the next rising edge.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// ID->EX pipeline register with optional skid entry, flush and bubble counter.
// One cycle latency; with SKID=1 in_ready is registered, with SKID=0 it follows out_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{NOP_PAYLOAD_FILL}},
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        occupancy
);

  stage_state_t      state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_data;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (out_xfer) begin
            main_q  <= NOP_VALUE;
            state_q <= ST_EMPTY;
          end else if (in_xfer) begin
            skid_q  <= in_data;
            state_q <= ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            skid_q  <= NOP_VALUE;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_VALUE;
          skid_q  <= NOP_VALUE;
        end
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      // Ready drops exactly when the next state is SKID.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= !(((state_q == ST_FULL) && in_xfer && !out_xfer) ||
                     ((state_q == ST_SKID) && !out_xfer));
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = (state_q == ST_EMPTY) || out_ready;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (out_ready && !out_valid && !flush),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: scoreboard on the skid instance,
// direct checks on a single-entry (SKID=0) instance.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [3:0]  bubble_cnt;
  logic [1:0]  occupancy;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_bubble_cnt;
  logic [1:0]  b_occupancy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .occupancy(occupancy)
  );

  pipe_skid_reg #(.DATA_W(32), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .bubble_cnt(b_bubble_cnt), .occupancy(b_occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: the edge following this negedge commits whatever handshakes are visible now.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!out_valid) chk("nop_data", out_data, 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_data, 32'hxxxx_xxxx);
        end else begin
          chk("out_order", out_data, exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    step(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    rst = 1'b0;

    // Streaming
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11; step(1);
    chk("stream_d0", out_data, 32'h11);
    chk("stream_occ0", 32'(occupancy), 32'd1);
    in_data = 32'h22; step(1);
    chk("stream_d1", out_data, 32'h22);
    chk("stream_occ1", 32'(occupancy), 32'd1);
    in_data = 32'h33; step(1);
    chk("stream_d2", out_data, 32'h33);
    chk("stream_occ2", 32'(occupancy), 32'd1);
    in_valid = 1'b0; step(1);
    chk("stream_empty", 32'(occupancy), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; step(1);
    chk("bp_main", out_data, 32'hA1);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    in_data = 32'hA2; step(1);
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    in_data = 32'hA3; step(2);
    chk("bp_hold_main", out_data, 32'hA1);
    chk("bp_hold_occ", 32'(occupancy), 32'd2);
    out_ready = 1'b1; step(1);
    chk("bp_rel_a2", out_data, 32'hA2);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    step(1);
    chk("bp_rel_a3", out_data, 32'hA3);
    in_valid = 1'b0; step(1);
    chk("bp_drained", 32'(occupancy), 32'd0);

    // Flush in SKID with a discarded input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; step(1);
    in_data = 32'hB2; step(1);
    chk("fl_occ_before", 32'(occupancy), 32'd2);
    in_data = 32'hFF; flush = 1'b1; step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_data", out_data, 32'h0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    // Flush in FULL, where the concurrent input would otherwise be accepted
    in_valid = 1'b1; in_data = 32'hC1; step(1);
    in_data = 32'hFF; flush = 1'b1; step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1; step(3);

    // Reset mid-operation drops held words
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hD1; step(1);
    in_valid = 1'b0; rst = 1'b1; step(1);
    rst = 1'b0;
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_data", out_data, 32'h0);

    // Bubble counter: no count on flush, then saturation
    out_ready = 1'b1; flush = 1'b1; step(1);
    chk("bub_flush", 32'(bubble_cnt), 32'd0);
    flush = 1'b0; step(1);
    chk("bub_1", 32'(bubble_cnt), 32'd1);
    step(13);
    chk("bub_14", 32'(bubble_cnt), 32'd14);
    step(1);
    chk("bub_15", 32'(bubble_cnt), 32'd15);
    step(6);
    chk("bub_sat", 32'(bubble_cnt), 32'd15);

    // Single-entry variant: combinational in_ready
    b_in_valid = 1'b1; b_in_data = 32'h5; step(1);
    chk("b_full", 32'(b_occupancy), 32'd1);
    b_in_valid = 1'b0; #1;
    chk("b_rdy_low", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1; #1;
    chk("b_rdy_comb", 32'(b_in_ready), 32'd1);
    b_in_valid = 1'b1; b_in_data = 32'h6; step(1);
    chk("b_pushpop_occ", 32'(b_occupancy), 32'd1);
    chk("b_pushpop_data", b_out_data, 32'h6);
    b_in_valid = 1'b0; step(1);
    chk("b_empty", 32'(b_occupancy), 32'd0);
    chk("b_nop", b_out_data, 32'h0);

    step(2);
    chk("queue_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
